// File: rtl/lsq_pkg.sv
// Shared defaults and field positions for the load/store shift-queue issuer.
// The top-level valid/ready flags sit in the two most significant bits of an entry.
package lsq_pkg;
  localparam int N_ENTRIES   = 8;
  localparam int ENTRY_WIDTH = 81;
  localparam int VLD_BIT     = ENTRY_WIDTH - 1;
  localparam int RDY_BIT     = ENTRY_WIDTH - 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } issue_state_e;

  // Flag positions for an arbitrary entry width (same layout as the defaults).
  function automatic int vld_bit(input int width);
    return width - 1;
  endfunction

  function automatic int rdy_bit(input int width);
    return width - 2;
  endfunction
endpackage

// File: rtl/shift_queue_issuer_if.sv
// Dequeue and issue handshake bundle between the shift queue, the issuer and the memory pipeline.
// master = issuer side, slave = queue / pipeline side.
interface shift_queue_issuer_if #(
  parameter int N_ENTRIES   = lsq_pkg::N_ENTRIES,
  parameter int ENTRY_WIDTH = lsq_pkg::ENTRY_WIDTH
);
  logic                   deq_ready;
  logic [N_ENTRIES-1:0]   deq_sel_onehot;
  logic                   deq_valid;
  logic [ENTRY_WIDTH-1:0] deq_data;
  logic                   issue_valid;
  logic                   issue_ready;
  logic [ENTRY_WIDTH-1:0] issue_data;

  modport master (
    output deq_ready, deq_sel_onehot, issue_valid, issue_data,
    input  deq_valid, deq_data, issue_ready
  );

  modport slave (
    input  deq_ready, deq_sel_onehot, issue_valid, issue_data,
    output deq_valid, deq_data, issue_ready
  );
endinterface

// File: rtl/onehot_lsb_picker.sv
// Returns a one-hot vector of the lowest set request bit (all zero when no request).
module onehot_lsb_picker #(
  parameter int N = 8
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);
  // Two's-complement trick isolates the least significant set bit.
  assign gnt_o = req_i & (~req_i + N'(1));
endmodule

// File: rtl/shift_queue_issuer.sv
// Picks the oldest ready entry of a compacting shift queue, holds it in one register
// and offers it to the memory pipeline with a valid/ready handshake at one entry per cycle.
module shift_queue_issuer #(
  parameter int N_ENTRIES   = lsq_pkg::N_ENTRIES,
  parameter int ENTRY_WIDTH = lsq_pkg::ENTRY_WIDTH,
  parameter int IN_ORDER    = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_aH,
  input  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] entry_douts,
  input  logic                                  flush,
  output logic [15:0]                           issued_cnt,
  shift_queue_issuer_if.master                  bus
);
  localparam int VLD_B = lsq_pkg::vld_bit(ENTRY_WIDTH);
  localparam int RDY_B = lsq_pkg::rdy_bit(ENTRY_WIDTH);

  lsq_pkg::issue_state_e  state_q;
  logic [ENTRY_WIDTH-1:0] data_q;
  logic [15:0]            cnt_q;
  logic [15:0]            cnt_d;

  logic [N_ENTRIES-1:0] cand;
  logic [N_ENTRIES-1:0] pick;
  logic                 any_cand;
  logic                 issue_valid;
  logic                 deq_ready;
  logic                 deq_fire;
  logic                 issue_hs;
  logic                 unused_payload;

  for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_cand
    if (IN_ORDER != 0 && gi > 0) begin : g_blocked
      assign cand[gi] = 1'b0;
    end else begin : g_open
      assign cand[gi] = entry_douts[gi][VLD_B] & entry_douts[gi][RDY_B];
    end
  end

  // Only the flag bits are inspected here; payload reaches us through deq_data.
  assign unused_payload = ^entry_douts;

  onehot_lsb_picker #(
    .N (N_ENTRIES)
  ) u_picker (
    .req_i (cand),
    .gnt_o (pick)
  );

  assign any_cand    = |cand;
  assign issue_valid = (state_q == lsq_pkg::ST_HELD);
  assign deq_ready   = any_cand & ~flush & ~rst_aH & (~issue_valid | bus.issue_ready);
  assign deq_fire    = deq_ready & bus.deq_valid;
  assign issue_hs    = issue_valid & bus.issue_ready;
  assign cnt_d       = cnt_q + 16'd1;

  assign bus.deq_ready      = deq_ready;
  assign bus.deq_sel_onehot = deq_ready ? pick : '0;
  assign bus.issue_valid    = issue_valid;
  assign bus.issue_data     = data_q;
  assign issued_cnt         = cnt_q;

  always_ff @(posedge clk) begin
    if (rst_aH) begin
      state_q <= lsq_pkg::ST_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (issue_hs) begin
        cnt_q <= cnt_d;
      end
      case (state_q)
        lsq_pkg::ST_EMPTY: begin
          if (deq_fire) begin
            state_q <= lsq_pkg::ST_HELD;
            data_q  <= bus.deq_data;
          end
        end
        lsq_pkg::ST_HELD: begin
          // A dequeue here implies a same-cycle handshake, so the slot is simply refilled.
          if (flush) begin
            state_q <= lsq_pkg::ST_EMPTY;
          end else if (deq_fire) begin
            data_q <= bus.deq_data;
          end else if (issue_hs) begin
            state_q <= lsq_pkg::ST_EMPTY;
          end
        end
        default: state_q <= lsq_pkg::ST_EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_queue_issuer.sv
// Self-checking bench: a compacting queue model feeds the issuer, a scoreboard tracks issued entries.
module tb_shift_queue_issuer;
  import lsq_pkg::*;

  localparam int N = lsq_pkg::N_ENTRIES;
  localparam int W = lsq_pkg::ENTRY_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_aH;
  logic                flush;
  logic                flush1;
  logic [N-1:0][W-1:0] mem;
  logic [N-1:0][W-1:0] mem1;
  logic [15:0]         cnt;
  logic [15:0]         cnt1;

  shift_queue_issuer_if #(.N_ENTRIES(N), .ENTRY_WIDTH(W)) bus ();
  shift_queue_issuer_if #(.N_ENTRIES(N), .ENTRY_WIDTH(W)) bus1 ();

  shift_queue_issuer #(.N_ENTRIES(N), .ENTRY_WIDTH(W), .IN_ORDER(0)) dut (
    .clk         (clk),
    .rst_aH      (rst_aH),
    .entry_douts (mem),
    .flush       (flush),
    .issued_cnt  (cnt),
    .bus         (bus)
  );

  shift_queue_issuer #(.N_ENTRIES(N), .ENTRY_WIDTH(W), .IN_ORDER(1)) dut_fifo (
    .clk         (clk),
    .rst_aH      (rst_aH),
    .entry_douts (mem1),
    .flush       (flush1),
    .issued_cnt  (cnt1),
    .bus         (bus1)
  );

  // The queue returns whichever entry the issuer selects.
  always_comb begin
    bus.deq_data = '0;
    for (int i = 0; i < N; i++)
      if (bus.deq_sel_onehot[i]) bus.deq_data = mem[i];
  end
  assign bus1.deq_data = '0;

  int          total;
  int          bad;
  int          count;
  int          tag_ctr;
  bit          quiet;
  bit          exp_valid;
  logic [15:0] exp_cnt;
  logic [W-1:0] sb[$];

  function automatic logic [W-1:0] mk(input bit r, input int tag);
    logic [W-1:0] e;
    e          = '0;
    e[VLD_BIT] = 1'b1;
    e[RDY_BIT] = r;
    e[31:0]    = tag;
    e[63:32]   = $urandom();
    return e;
  endfunction

  task automatic push_entry(input bit r, input int tag);
    if (count < N) begin
      mem[count] = mk(r, tag);
      count++;
    end
  endtask

  task automatic remove_entry(input int sel);
    for (int i = sel; i < N - 1; i++) mem[i] = mem[i + 1];
    mem[N-1] = '0;
    count--;
  endtask

  // One clock of traffic: checks the combinational dequeue side, runs the scoreboard,
  // advances the edge and checks the counter.
  task automatic cycle();
    int           sel;
    bit           exp_ready;
    bit           fire;
    bit           hs;
    logic [N-1:0] exp_oh;
    logic [W-1:0] entry;
    logic [W-1:0] popped;
    #1;
    sel = -1;
    for (int i = 0; i < N; i++)
      if (sel < 0 && mem[i][VLD_BIT] && mem[i][RDY_BIT]) sel = i;
    exp_ready = (sel >= 0) && !flush && !rst_aH && (!exp_valid || bus.issue_ready);
    exp_oh = '0;
    if (exp_ready) exp_oh[sel] = 1'b1;
    total++;
    if (bus.deq_ready !== exp_ready) begin
      bad++;
      $display("FAIL deq_ready: got %b want %b", bus.deq_ready, exp_ready);
    end
    total++;
    if (bus.deq_sel_onehot !== exp_oh) begin
      bad++;
      $display("FAIL deq_sel_onehot: got %b want %b", bus.deq_sel_onehot, exp_oh);
    end
    total++;
    if (bus.issue_valid !== exp_valid) begin
      bad++;
      $display("FAIL issue_valid: got %b want %b", bus.issue_valid, exp_valid);
    end
    if (exp_valid && sb.size() > 0) begin
      total++;
      if (bus.issue_data !== sb[0]) begin
        bad++;
        $display("FAIL issue_data: got %h want %h", bus.issue_data, sb[0]);
      end
    end
    hs    = exp_valid && bus.issue_ready;
    fire  = exp_ready && bus.deq_valid;
    entry = '0;
    if (fire) entry = mem[sel];
    if (rst_aH) begin
      sb.delete();
      exp_valid = 1'b0;
      exp_cnt   = '0;
    end else begin
      if (hs) begin
        popped = sb.pop_front();
        exp_cnt++;
        if (!quiet) $display("txn issue cnt=%0d data=%h", exp_cnt, popped);
      end
      if (flush) begin
        if (exp_valid && !hs) popped = sb.pop_front();
        exp_valid = 1'b0;
      end else if (fire) begin
        sb.push_back(entry);
        exp_valid = 1'b1;
      end else if (hs) begin
        exp_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (fire) remove_entry(sel);
    total++;
    if (cnt !== exp_cnt) begin
      bad++;
      $display("FAIL issued_cnt: got %h want %h", cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst_aH          = 1'b1;
    flush           = 1'b0;
    flush1          = 1'b0;
    mem             = '0;
    mem1            = '0;
    count           = 0;
    tag_ctr         = 1000;
    quiet           = 1'b0;
    exp_valid       = 1'b0;
    exp_cnt         = '0;
    bus.deq_valid   = 1'b1;
    bus.issue_ready = 1'b1;
    bus1.deq_valid  = 1'b0;
    bus1.issue_ready = 1'b1;
    @(posedge clk);
    #1;
    push_entry(1'b1, 1);
    #1;
    total++;
    if (bus.deq_ready !== 1'b0 || bus.deq_sel_onehot !== '0) begin
      bad++;
      $display("FAIL reset_deq_gate: got ready=%b sel=%b want 0/0", bus.deq_ready, bus.deq_sel_onehot);
    end
    cycle();
    total++;
    if (bus.issue_valid !== 1'b0 || bus.issue_data !== '0 || cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%b d=%h c=%h want 0/0/0", bus.issue_valid, bus.issue_data, cnt);
    end
    rst_aH = 1'b0;
    mem    = '0;
    count  = 0;
    cycle();
  endtask

  task automatic test_pick_oldest();
    logic [W-1:0] e2;
    logic [W-1:0] e5;
    push_entry(1'b0, 10);
    push_entry(1'b0, 11);
    push_entry(1'b1, 12);
    push_entry(1'b0, 13);
    push_entry(1'b0, 14);
    push_entry(1'b1, 15);
    e2 = mem[2];
    e5 = mem[5];
    bus.issue_ready = 1'b1;
    #1;
    total++;
    if (bus.deq_sel_onehot !== 8'b00000100) begin
      bad++;
      $display("FAIL pick_sel: got %b want 00000100", bus.deq_sel_onehot);
    end
    cycle();
    total++;
    if (bus.issue_valid !== 1'b1 || bus.issue_data !== e2) begin
      bad++;
      $display("FAIL pick_data: got v=%b d=%h want 1/%h", bus.issue_valid, bus.issue_data, e2);
    end
    cycle();
    total++;
    if (bus.issue_data !== e5) begin
      bad++;
      $display("FAIL pick_second: got %h want %h", bus.issue_data, e5);
    end
    cycle();
    cycle();
    mem   = '0;
    count = 0;
  endtask

  task automatic test_in_order();
    mem1 = '0;
    mem1[0] = mk(1'b0, 40);
    mem1[1] = mk(1'b0, 41);
    mem1[2] = mk(1'b0, 42);
    mem1[3] = mk(1'b1, 43);
    #1;
    total++;
    if (bus1.deq_ready !== 1'b0 || bus1.deq_sel_onehot !== '0) begin
      bad++;
      $display("FAIL in_order_block: got ready=%b sel=%b want 0/0", bus1.deq_ready, bus1.deq_sel_onehot);
    end
    mem1[0][RDY_BIT] = 1'b1;
    #1;
    total++;
    if (bus1.deq_ready !== 1'b1 || bus1.deq_sel_onehot !== 8'b00000001) begin
      bad++;
      $display("FAIL in_order_head: got ready=%b sel=%b want 1/00000001", bus1.deq_ready, bus1.deq_sel_onehot);
    end
    mem1 = '0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    logic [15:0]  c0;
    push_entry(1'b1, 20);
    push_entry(1'b1, 21);
    held = mem[0];
    bus.issue_ready = 1'b1;
    cycle();
    bus.issue_ready = 1'b0;
    c0 = exp_cnt;
    for (int k = 0; k < 4; k++) begin
      cycle();
      total++;
      if (bus.issue_data !== held || bus.deq_ready !== 1'b0 || cnt !== c0) begin
        bad++;
        $display("FAIL stall_%0d: got d=%h r=%b c=%h want %h/0/%h", k, bus.issue_data, bus.deq_ready, cnt, held, c0);
      end
    end
    bus.issue_ready = 1'b1;
    cycle();
    total++;
    if (cnt !== c0 + 16'd1) begin
      bad++;
      $display("FAIL stall_release: got %h want %h", cnt, c0 + 16'd1);
    end
    cycle();
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] snap[N];
    logic [15:0]  c0;
    for (int i = 0; i < N; i++) push_entry(1'b1, 100 + i);
    for (int i = 0; i < N; i++) snap[i] = mem[i];
    c0 = exp_cnt;
    bus.issue_ready = 1'b1;
    cycle();
    for (int k = 0; k < N; k++) begin
      total++;
      if (bus.issue_valid !== 1'b1 || bus.issue_data !== snap[k]) begin
        bad++;
        $display("FAIL b2b_%0d: got v=%b d=%h want 1/%h", k, bus.issue_valid, bus.issue_data, snap[k]);
      end
      cycle();
    end
    total++;
    if (cnt !== c0 + 16'd8 || bus.issue_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done: got c=%h v=%b want %h/0", cnt, bus.issue_valid, c0 + 16'd8);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] e31;
    logic [15:0]  c0;
    push_entry(1'b1, 30);
    push_entry(1'b1, 31);
    e31 = mem[1];
    bus.issue_ready = 1'b1;
    cycle();
    bus.issue_ready = 1'b0;
    flush = 1'b1;
    #1;
    total++;
    if (bus.deq_ready !== 1'b0 || bus.deq_sel_onehot !== '0) begin
      bad++;
      $display("FAIL flush_gate: got ready=%b sel=%b want 0/0", bus.deq_ready, bus.deq_sel_onehot);
    end
    c0 = exp_cnt;
    cycle();
    flush = 1'b0;
    total++;
    if (bus.issue_valid !== 1'b0 || cnt !== c0) begin
      bad++;
      $display("FAIL flush_drop: got v=%b c=%h want 0/%h", bus.issue_valid, cnt, c0);
    end
    cycle();
    total++;
    if (bus.issue_valid !== 1'b1 || bus.issue_data !== e31) begin
      bad++;
      $display("FAIL flush_refill: got v=%b d=%h want 1/%h", bus.issue_valid, bus.issue_data, e31);
    end
    push_entry(1'b1, 32);
    bus.issue_ready = 1'b1;
    flush = 1'b1;
    c0 = exp_cnt;
    cycle();
    flush = 1'b0;
    total++;
    if (cnt !== c0 + 16'd1 || bus.issue_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_with_hs: got c=%h v=%b want %h/0", cnt, bus.issue_valid, c0 + 16'd1);
    end
    cycle();
    cycle();
    cycle();
  endtask

  task automatic test_wrap_and_reset();
    int guard;
    rst_aH = 1'b1;
    cycle();
    rst_aH = 1'b0;
    quiet  = 1'b1;
    bus.issue_ready = 1'b1;
    while (count < N) begin
      push_entry(1'b1, tag_ctr);
      tag_ctr++;
    end
    guard = 0;
    while (exp_cnt != 16'hFFFF && guard < 70000) begin
      cycle();
      while (count < N) begin
        push_entry(1'b1, tag_ctr);
        tag_ctr++;
      end
      guard++;
    end
    if (guard >= 70000) begin
      total++;
      bad++;
      $display("FAIL wrap_timeout: got %h want ffff", exp_cnt);
    end
    quiet = 1'b0;
    total++;
    if (cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_preload: got %h want ffff", cnt);
    end
    cycle();
    total++;
    if (cnt !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_rollover: got %h want 0000", cnt);
    end
    rst_aH = 1'b1;
    #1;
    total++;
    if (bus.deq_ready !== 1'b0 || bus.deq_sel_onehot !== '0) begin
      bad++;
      $display("FAIL midreset_gate: got ready=%b sel=%b want 0/0", bus.deq_ready, bus.deq_sel_onehot);
    end
    cycle();
    rst_aH = 1'b0;
    total++;
    if (bus.issue_valid !== 1'b0 || bus.issue_data !== '0 || cnt !== 16'd0) begin
      bad++;
      $display("FAIL midreset_state: got v=%b d=%h c=%h want 0/0/0", bus.issue_valid, bus.issue_data, cnt);
    end
    mem   = '0;
    count = 0;
    cycle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_pick_oldest();
    test_in_order();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_queue_issuer.md
SHIFT_QUEUE_ISSUER -- requirements
Module: shift_queue_issuer

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 8, number of shift-queue entries observed.
REQ-002 SHALL have parameter ENTRY_WIDTH, default 81, LSQ entry width.
REQ-003 SHALL have parameter IN_ORDER, default 0; 1 = only entry 0 eligible (FIFO mode).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_aH  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port entry_douts  input  N_ENTRIES x ENTRY_WIDTH  all queue entries, index 0 oldest.
REQ-007 SHALL have port deq_ready  output  1  dequeue request to queue.
REQ-008 SHALL have port deq_sel_onehot  output  N_ENTRIES  selected entry, one-hot or all 0.
REQ-009 SHALL have port deq_valid  input  1  queue confirms dequeue possible.
REQ-010 SHALL have port deq_data  input  ENTRY_WIDTH  dequeued entry contents.
REQ-011 SHALL have port issue_valid  output  1  entry available to memory pipeline.
REQ-012 SHALL have port issue_ready  input  1  memory pipeline accepts.
REQ-013 SHALL have port issue_data  output  ENTRY_WIDTH  issued entry.
REQ-014 SHALL have port flush  input  1  discard held entry, suppress dequeue this cycle.
REQ-015 SHALL have port issued_cnt  output  16  count of completed issue handshakes.

Function
REQ-016 Candidate[i] SHALL = entry_douts[i][VLD_BIT] & entry_douts[i][RDY_BIT]; with IN_ORDER=1 candidate[i>0] SHALL be forced 0.
REQ-017 deq_sel_onehot SHALL be lowest-index candidate (oldest), combinational from entry_douts; all 0 if no candidate.
REQ-018 deq_ready SHALL = any candidate & ~flush & (~issue_valid | issue_ready).
REQ-019 deq_sel_onehot SHALL be driven all 0 whenever deq_ready=0.
REQ-020 Dequeue event SHALL be deq_ready & deq_valid; on it, holding register SHALL capture deq_data and issue_valid SHALL be 1 next cycle (latency 1).
REQ-021 Issue handshake issue_valid & issue_ready without same-cycle dequeue SHALL clear issue_valid next cycle.
REQ-022 Simultaneous issue handshake and dequeue SHALL replace holding register, issue_valid stays 1 (full throughput, 1 entry/cycle).
REQ-023 issue_valid=1 & issue_ready=0 SHALL hold issue_data stable and keep deq_ready=0.
REQ-024 flush SHALL clear issue_valid next cycle; issued_cnt SHALL still count a same-cycle handshake.
REQ-025 issued_cnt SHALL increment by 1 per handshake and wrap 0xFFFF -> 0x0000.
REQ-026 Queue compaction after dequeue SHALL be relied on; block SHALL hold no per-entry state and never reselect the same entry.
REQ-027 States: EMPTY (issue_valid=0), HELD (issue_valid=1); EMPTY->HELD on dequeue; HELD->EMPTY on handshake w/o dequeue or on flush; HELD->HELD otherwise.

Reset
REQ-028 On rst_aH=1 at clk edge: issue_valid=0, issue_data=0, issued_cnt=0, state EMPTY.
REQ-029 While rst_aH=1, deq_ready and deq_sel_onehot SHALL be 0 combinationally; reset mid-transfer SHALL drop held entry without counting.

Structure
REQ-030 Package lsq_pkg SHALL hold N_ENTRIES, ENTRY_WIDTH defaults and VLD_BIT=ENTRY_WIDTH-1, RDY_BIT=ENTRY_WIDTH-2.
REQ-031 Sub-module onehot_lsb_picker (N-bit request -> one-hot lowest set bit) SHALL implement REQ-017.
REQ-032 Holding register and counter SHALL be the only state; no combinational path from issue_ready to issue_data.

Verification
REQ-033 Entries 2 and 5 candidate, issue_ready=1 -> deq_sel_onehot=0b00000100, issue_data=entry 2 one cycle later.
REQ-034 IN_ORDER=1, entry 0 valid not ready, entry 3 candidate -> deq_ready=0, deq_sel_onehot=0.
REQ-035 issue_ready=0 for 4 cycles with HELD -> issue_data constant, deq_ready=0, issued_cnt unchanged; release -> 1 handshake counted.
REQ-036 8 back-to-back candidates, issue_ready=1 -> 8 issues in 8 consecutive cycles, issued_cnt=8, oldest first.
REQ-037 flush while HELD and issue_ready=0 -> issue_valid=0 next cycle, deq_ready=0 in flush cycle, issued_cnt unchanged.
REQ-038 issued_cnt preloaded to 0xFFFF via 65535 handshakes, one more -> 0x0000; rst_aH mid-HELD -> all outputs 0 next cycle.
